// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM state encoding, bit-count
// constants and the default device address used by initiator and target.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK
  } i2c_tgt_state_t;

  localparam int BYTE_BITS = 8;
  localparam int ACK_BIT   = 8;

  localparam logic [6:0] I2C_DEFAULT_DEV_ADDR = 7'h1A;

  // Register pointer advance; natural 8-bit wrap from 8'hFF to 8'h00.
  function automatic logic [7:0] ptr_next(input logic [7:0] p);
    return p + 8'd1;
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronizers for SCL/SDA plus registered bus-event pulses.
// sda_lvl is delayed one extra stage so it lines up with the event pulses.
module i2c_bus_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_lvl
);

  logic scl_meta_q, scl_meta_d, scl_sync_q, scl_sync_d, scl_prev_q, scl_prev_d;
  logic sda_meta_q, sda_meta_d, sda_sync_q, sda_sync_d, sda_prev_q, sda_prev_d;
  logic rise_q, rise_d, fall_q, fall_d, start_q, start_d, stop_q, stop_d;

  // Next-state for the synchronizer chains and the edge/condition pulses
  always_comb begin
    scl_meta_d = scl_i;
    scl_sync_d = scl_meta_q;
    scl_prev_d = scl_sync_q;
    sda_meta_d = sda_i;
    sda_sync_d = sda_meta_q;
    sda_prev_d = sda_sync_q;
    rise_d     = scl_sync_q & ~scl_prev_q;
    fall_d     = ~scl_sync_q & scl_prev_q;
    start_d    = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
    stop_d     = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;
  end

  // Bus idles high, so the chains reset to 1 to avoid phantom events
  always_ff @(posedge clk) begin
    if (!reset) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_meta_q <= scl_meta_d;
      scl_sync_q <= scl_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_meta_q <= sda_meta_d;
      sda_sync_q <= sda_sync_d;
      sda_prev_q <= sda_prev_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
    end
  end

  assign scl_rise  = rise_q;
  assign scl_fall  = fall_q;
  assign start_det = start_q;
  assign stop_det  = stop_q;
  assign sda_lvl   = sda_prev_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target: address match, register pointer, auto-increment writes and
// register-file reads. wr_valid and rd_req are single-cycle strobes with no
// back-pressure (valid without ready): the register file must accept a write
// on the strobe cycle and present rd_data two cycles after rd_req.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = I2C_DEFAULT_DEV_ADDR
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           scl_i,
  input  logic           sda_i,
  output logic           sda_oe,
  output logic           wr_valid,
  output logic [7:0]     wr_addr,
  output logic [7:0]     wr_data,
  output logic           rd_req,
  output logic [7:0]     rd_addr,
  input  logic [7:0]     rd_data,
  output logic           busy,
  output i2c_tgt_state_t dbg_state,
  output logic [7:0]     dbg_ptr
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_lvl;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_lvl   (sda_lvl)
  );

  i2c_tgt_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d, ptr_q, ptr_d;
  logic       rw_q, rw_d, sda_oe_q, sda_oe_d, busy_q, busy_d;
  logic       wr_valid_q, wr_valid_d, rd_req_q, rd_req_d;
  logic [7:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d, rd_addr_q, rd_addr_d;
  logic       rd_p1_q, rd_p1_d, rd_p2_q, rd_p2_d;
  logic [7:0] byte_in;
  logic       last_bit;

  // FSM next-state: bus conditions first, then per-state bit handling
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_req_d   = 1'b0;
    rd_addr_d  = rd_addr_q;
    rd_p1_d    = rd_req_q;
    rd_p2_d    = rd_p1_q;
    byte_in    = {shift_q[6:0], sda_lvl};
    last_bit   = (cnt_q == 4'(BYTE_BITS - 1));

    // Read data arrives two cycles after the request, long before SCL falls
    if (rd_p2_q) shift_d = rd_data;

    if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      cnt_d    = 4'd0;
    end else if (start_det) begin
      state_d  = ST_ADDR;
      sda_oe_d = 1'b0;
      cnt_d    = 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_ADDR: if (scl_rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 4'd1;
          if (last_bit) begin
            if (byte_in[7:1] == DEV_ADDR) begin
              state_d = ST_ADDR_ACK;
              busy_d  = 1'b1;
              rw_d    = byte_in[0];
              if (byte_in[0]) begin
                rd_req_d  = 1'b1;
                rd_addr_d = ptr_q;
              end
            end else begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end
          end
        end
        ST_ADDR_ACK: if (scl_fall) begin
          if (cnt_q == 4'(ACK_BIT)) begin
            sda_oe_d = 1'b1;
            cnt_d    = cnt_q + 4'd1;
          end else if (rw_q) begin
            // The fall that ends the ACK also launches the first read bit
            sda_oe_d = ~shift_q[7];
            shift_d  = {shift_q[6:0], 1'b0};
            cnt_d    = 4'd1;
            state_d  = ST_RDATA;
          end else begin
            sda_oe_d = 1'b0;
            cnt_d    = 4'd0;
            state_d  = ST_REG;
          end
        end
        ST_REG: if (scl_rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 4'd1;
          if (last_bit) begin
            ptr_d   = byte_in;
            state_d = ST_REG_ACK;
          end
        end
        ST_REG_ACK: if (scl_fall) begin
          if (cnt_q == 4'(ACK_BIT)) begin
            sda_oe_d = 1'b1;
            cnt_d    = cnt_q + 4'd1;
          end else begin
            sda_oe_d = 1'b0;
            cnt_d    = 4'd0;
            state_d  = ST_WDATA;
          end
        end
        ST_WDATA: if (scl_rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 4'd1;
          if (last_bit) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = ptr_q;
            wr_data_d  = byte_in;
            state_d    = ST_WDATA_ACK;
          end
        end
        ST_WDATA_ACK: if (scl_fall) begin
          if (cnt_q == 4'(ACK_BIT)) begin
            sda_oe_d = 1'b1;
            cnt_d    = cnt_q + 4'd1;
          end else begin
            sda_oe_d = 1'b0;
            cnt_d    = 4'd0;
            ptr_d    = ptr_next(ptr_q);
            state_d  = ST_WDATA;
          end
        end
        ST_RDATA: if (scl_fall) begin
          if (cnt_q < 4'(BYTE_BITS)) begin
            sda_oe_d = ~shift_q[7];
            shift_d  = {shift_q[6:0], 1'b0};
            cnt_d    = cnt_q + 4'd1;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = ST_RDATA_ACK;
          end
        end
        ST_RDATA_ACK: if (scl_rise) begin
          if (!sda_lvl) begin
            ptr_d     = ptr_next(ptr_q);
            rd_req_d  = 1'b1;
            rd_addr_d = ptr_next(ptr_q);
            cnt_d     = 4'd0;
            state_d   = ST_RDATA;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= 8'd0;
      ptr_q      <= 8'd0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 8'd0;
      wr_data_q  <= 8'd0;
      rd_req_q   <= 1'b0;
      rd_addr_q  <= 8'd0;
      rd_p1_q    <= 1'b0;
      rd_p2_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_req_q   <= rd_req_d;
      rd_addr_q  <= rd_addr_d;
      rd_p1_q    <= rd_p1_d;
      rd_p2_q    <= rd_p2_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_req    = rd_req_q;
  assign rd_addr   = rd_addr_q;
  assign dbg_state = state_q;
  assign dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged initiator, open-drain bus model,
// scoreboard queues for write strobes, read requests and read data.
module tb_i2c_target;
  import i2c_pkg::*;

  localparam int Q = 6;  // quarter SCL period in clk cycles

  logic clk, reset, scl_drv, sda_drv;
  logic sda_bus;
  logic sda_oe, wr_valid, rd_req, busy;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data, dbg_ptr;
  i2c_tgt_state_t dbg_state;

  int checks = 0;
  int errors = 0;
  int oe_cnt = 0;
  int busy_cnt = 0;

  logic [15:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  logic [7:0]  exp_rdata[$];

  assign sda_bus = sda_drv & ~sda_oe;
  // Register file read port model
  assign rd_data = (rd_addr == 8'hFF) ? 8'h3C : (rd_addr == 8'h00) ? 8'hC3 : 8'hEE;

  i2c_target dut (
    .clk       (clk),
    .reset     (reset),
    .scl_i     (scl_drv),
    .sda_i     (sda_bus),
    .sda_oe    (sda_oe),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard monitor for strobes, sampled away from the active edge
  always @(negedge clk) begin
    logic [15:0] ew;
    logic [7:0]  er;
    if (reset) begin
      if (wr_valid) begin
        if (exp_wr.size() == 0) check("wr_extra", 32'(wr_valid), 32'd0);
        else begin
          ew = exp_wr.pop_front();
          check("wr_strobe", {16'd0, wr_addr, wr_data}, {16'd0, ew});
        end
      end
      if (rd_req) begin
        if (exp_rd.size() == 0) check("rd_extra", 32'(rd_req), 32'd0);
        else begin
          er = exp_rd.pop_front();
          check("rd_addr", {24'd0, rd_addr}, {24'd0, er});
        end
      end
      if (sda_oe) oe_cnt++;
      if (busy) busy_cnt++;
    end
  end

  // driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1; wait_clk(Q);
    scl_drv = 1'b1; wait_clk(Q);
    sda_drv = 1'b0; wait_clk(Q);
    scl_drv = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; wait_clk(Q);
    scl_drv = 1'b1; wait_clk(Q);
    sda_drv = 1'b1; wait_clk(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_drv = b;    wait_clk(Q);
    scl_drv = 1'b1; wait_clk(2 * Q);
    scl_drv = 1'b0; wait_clk(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_drv = 1'b1; wait_clk(Q);
    scl_drv = 1'b1; wait_clk(Q);
    b = sda_bus;    wait_clk(Q);
    scl_drv = 1'b0; wait_clk(Q);
  endtask

  task automatic send(input logic [7:0] b, input logic exp_ack, input string tag);
    logic a;
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(a);
    check(tag, 32'(a), 32'(exp_ack));
  endtask

  task automatic recv(input logic ack, input string tag);
    logic [7:0] v;
    logic       bt;
    logic [7:0] e;
    for (int i = 7; i >= 0; i--) begin
      read_bit(bt);
      v[i] = bt;
    end
    write_bit(ack);
    e = exp_rdata.pop_front();
    check(tag, {24'd0, v}, {24'd0, e});
  endtask

  initial begin
    int n;
    reset = 1'b0; scl_drv = 1'b1; sda_drv = 1'b1;
    wait_clk(4);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_wr_valid", 32'(wr_valid), 32'd0);
    check("rst_rd_req", 32'(rd_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_ptr", 32'(dbg_ptr), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b1;
    wait_clk(4);

    // basic write with auto-increment
    exp_wr.push_back({8'h05, 8'hAA});
    exp_wr.push_back({8'h06, 8'h55});
    i2c_start();
    send({7'h1A, 1'b0}, 1'b0, "w1_addr_ack");
    check("w1_busy", 32'(busy), 32'd1);
    send(8'h05, 1'b0, "w1_ptr_ack");
    send(8'hAA, 1'b0, "w1_d0_ack");
    send(8'h55, 1'b0, "w1_d1_ack");
    i2c_stop();
    wait_clk(Q);
    check("w1_state", 32'(dbg_state), 32'(ST_IDLE));
    check("w1_busy_end", 32'(busy), 32'd0);
    check("w1_wr_left", 32'(exp_wr.size()), 32'd0);

    // address mismatch: target must stay silent
    oe_cnt = 0; busy_cnt = 0;
    i2c_start();
    send({7'h50, 1'b0}, 1'b1, "nm_addr_nack");
    send(8'h12, 1'b1, "nm_data_nack");
    i2c_stop();
    wait_clk(Q);
    check("nm_oe_cnt", 32'(oe_cnt), 32'd0);
    check("nm_busy_cnt", 32'(busy_cnt), 32'd0);
    check("nm_state", 32'(dbg_state), 32'(ST_IDLE));

    // write pointer, repeated START, read two bytes with wrap
    i2c_start();
    send({7'h1A, 1'b0}, 1'b0, "rd_waddr_ack");
    send(8'hFF, 1'b0, "rd_ptr_ack");
    exp_rd.push_back(8'hFF);
    exp_rd.push_back(8'h00);
    exp_rdata.push_back(8'h3C);
    exp_rdata.push_back(8'hC3);
    i2c_start();
    send({7'h1A, 1'b1}, 1'b0, "rd_raddr_ack");
    recv(1'b0, "rd_byte0");
    recv(1'b1, "rd_byte1");
    check("rd_state_nack", 32'(dbg_state), 32'(ST_IDLE));
    check("rd_busy_nack", 32'(busy), 32'd0);
    check("rd_oe_nack", 32'(sda_oe), 32'd0);
    i2c_stop();
    wait_clk(Q);
    check("rd_ptr", 32'(dbg_ptr), 32'h00);
    check("rd_req_left", 32'(exp_rd.size()), 32'd0);

    // STOP after 4 data bits drops the byte; next write is normal
    i2c_start();
    send({7'h1A, 1'b0}, 1'b0, "pb_addr_ack");
    send(8'h10, 1'b0, "pb_ptr_ack");
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    i2c_stop();
    wait_clk(Q);
    check("pb_state", 32'(dbg_state), 32'(ST_IDLE));
    exp_wr.push_back({8'h20, 8'h7E});
    i2c_start();
    send({7'h1A, 1'b0}, 1'b0, "pb2_addr_ack");
    send(8'h20, 1'b0, "pb2_ptr_ack");
    send(8'h7E, 1'b0, "pb2_d_ack");
    i2c_stop();
    wait_clk(Q);
    check("pb_wr_left", 32'(exp_wr.size()), 32'd0);
    check("pb_ptr", 32'(dbg_ptr), 32'h21);

    // reset pulse while the target drives ACK
    i2c_start();
    for (int i = 7; i >= 1; i--) write_bit(I2C_DEFAULT_DEV_ADDR[i-1]);
    write_bit(1'b0);
    sda_drv = 1'b1;
    n = 0;
    while (!sda_oe && n < 40) begin
      wait_clk(1);
      n++;
    end
    check("rs_oe_before", 32'(sda_oe), 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rs_oe_after", 32'(sda_oe), 32'd0);
    check("rs_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rs_ptr", 32'(dbg_ptr), 32'd0);
    check("rs_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    wait_clk(Q);
    i2c_stop();
    wait_clk(Q);

    // pointer wrap on writes
    exp_wr.push_back({8'hFF, 8'h11});
    exp_wr.push_back({8'h00, 8'h22});
    i2c_start();
    send({7'h1A, 1'b0}, 1'b0, "wr_addr_ack");
    send(8'hFF, 1'b0, "wr_ptr_ack");
    send(8'h11, 1'b0, "wr_d0_ack");
    send(8'h22, 1'b0, "wr_d1_ack");
    i2c_stop();
    wait_clk(Q);
    check("wr_wrap_left", 32'(exp_wr.size()), 32'd0);
    check("wr_wrap_ptr", 32'(dbg_ptr), 32'h01);
    check("end_rdata_left", 32'(exp_rdata.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
